alu_operand_loader: RTL and testbench

ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_cmd_fifo.sv | 69 ++++++
 rtl/alu_operand_loader.sv | 135 +++++++++++++
 tb/tb_alu_operand_loader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand loader: opcode encodings,
// command-type constants, the arming-state enum and the queue entry layout.
package alu_pkg;

  // ALU opcode encodings carried in a queued operation
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Command types found in cmd_data[7:6]
  localparam logic [1:0] CMD_LOAD_A = 2'b00;
  localparam logic [1:0] CMD_LOAD_B = 2'b01;
  localparam logic [1:0] CMD_GO     = 2'b10;
  localparam logic [1:0] CMD_CLEAR  = 2'b11;

  // Width of one queued operation: {opcode, A, B}
  localparam int ENTRY_W = 10;

  // Which operands have been loaded since the last GO / CLEAR
  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_A_ONLY = 2'b01,
    ST_B_ONLY = 2'b10,
    ST_ARMED  = 2'b11
  } arm_state_t;

  // One queued ALU operation
  typedef struct packed {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } alu_entry_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Small synchronous FIFO holding queued ALU operations.
// DEPTH must be a power of two; pointers wrap explicitly at DEPTH-1.
// The read port shows the head entry combinationally and reads as zero
// while the FIFO is empty, so stale storage never leaks to the outputs.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue in one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents beyond the live window are never observed
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_operand_loader.sv
// ALU operand loader: collects operand A, operand B and an opcode from a
// byte-wide command stream, queues armed operations and hands them to the
// ALU with a valid/ready handshake.
// Optional feature macro: ALU_LOADER_DIVZERO_CHECK_EN -- when defined, an
// armed DIV with B==0 is rejected and flagged on div_err; otherwise it is
// queued unchanged and div_err is tied low.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [7:0]               cmd_data,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [3:0]               issue_a,
  output logic [3:0]               issue_b,
  output logic [1:0]               issue_op,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     seq_err,
  output logic                     div_err
);

  arm_state_t state;
  logic [3:0] reg_a;
  logic [3:0] reg_b;
  logic       fifo_full;
  logic       fifo_empty;
  logic       cmd_accept;
  logic       issue_pop;
  logic [1:0] cmd_type;
  logic [3:0] payload;
  logic       go_armed;
  logic       div_reject;
  logic       do_push;
  logic       do_clear;
  alu_entry_t push_entry;
  alu_entry_t head_entry;
  logic       unused_cmd_bits;

  assign cmd_type        = cmd_data[7:6];
  assign payload         = cmd_data[3:0];
  assign unused_cmd_bits = ^cmd_data[5:4];

  assign cmd_ready   = ena & ~fifo_full;
  assign cmd_accept  = cmd_valid & cmd_ready;
  assign issue_valid = ~fifo_empty;
  assign issue_pop   = issue_valid & issue_ready & ena;
  assign issue_a     = head_entry.a;
  assign issue_b     = head_entry.b;
  assign issue_op    = head_entry.op;

  // Decide what an accepted command does to the queue this cycle
  always_comb begin
    go_armed   = cmd_accept && (cmd_type == CMD_GO) && (state == ST_ARMED);
    div_reject = 1'b0;
`ifdef ALU_LOADER_DIVZERO_CHECK_EN
    div_reject = go_armed && (cmd_data[1:0] == OP_DIV) && (reg_b == 4'd0);
`endif
    do_push    = go_armed && !div_reject;
    do_clear   = cmd_accept && (cmd_type == CMD_CLEAR);
    push_entry = '{op: cmd_data[1:0], a: reg_a, b: reg_b};
  end

  // Arming FSM with operand registers and the sequencing error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_EMPTY;
      reg_a   <= '0;
      reg_b   <= '0;
      seq_err <= 1'b0;
    end else if (cmd_accept) begin
      case (cmd_type)
        CMD_LOAD_A: begin
          reg_a <= payload;
          case (state)
            ST_EMPTY:  state <= ST_A_ONLY;
            ST_B_ONLY: state <= ST_ARMED;
            default:   state <= state;
          endcase
        end
        CMD_LOAD_B: begin
          reg_b <= payload;
          case (state)
            ST_EMPTY:  state <= ST_B_ONLY;
            ST_A_ONLY: state <= ST_ARMED;
            default:   state <= state;
          endcase
        end
        CMD_GO: begin
          if (state == ST_ARMED) state <= ST_EMPTY;
          else                   seq_err <= 1'b1;
        end
        default: begin
          state   <= ST_EMPTY;
          reg_a   <= '0;
          reg_b   <= '0;
          seq_err <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_LOADER_DIVZERO_CHECK_EN
  // Sticky divide-by-zero flag, cleared only by CLEAR or reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          div_err <= 1'b0;
    else if (do_clear)   div_err <= 1'b0;
    else if (div_reject) div_err <= 1'b1;
  end
`else
  assign div_err = 1'b0;
`endif

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (do_push),
    .pop   (issue_pop),
    .flush (do_clear),
    .wdata (push_entry),
    .rdata (head_entry),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (level)
  );

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader: a directed vector table,
// hand-written corner sequences and a randomized run against a queue model.
module tb_alu_operand_loader;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef ALU_LOADER_DIVZERO_CHECK_EN
  localparam bit DIV_CHECK = 1'b1;
`else
  localparam bit DIV_CHECK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic [7:0]    cmd_data = 8'h00;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          issue_valid;
  logic          issue_ready = 1'b0;
  logic [3:0]    issue_a;
  logic [3:0]    issue_b;
  logic [1:0]    issue_op;
  logic [LW-1:0] level;
  logic          seq_err;
  logic          div_err;

  int num_checks = 0;
  int num_fails  = 0;

  alu_operand_loader #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .cmd_data    (cmd_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_a     (issue_a),
    .issue_b     (issue_b),
    .issue_op    (issue_op),
    .level       (level),
    .seq_err     (seq_err),
    .div_err     (div_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: a queue of operations plus "which operands are loaded"
  typedef struct { int op; int a; int b; } op_t;
  op_t model_q[$];
  bit  have_a, have_b;
  int  model_a, model_b;
  bit  model_seq, model_div;

  // Directed vector table record
  typedef struct {
    bit e; bit v; logic [7:0] d; bit r;
    bit x_valid; int x_a; int x_b; int x_op; int x_level; bit x_seq; bit x_rdy;
  } vec_t;
  vec_t vecs[$];

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    model_q.delete();
    have_a = 0; have_b = 0;
    model_a = 0; model_b = 0;
    model_seq = 0; model_div = 0;
  endtask

  task automatic modelStep(input bit e, input bit v, input logic [7:0] d, input bit r);
    int  kind;
    int  nib;
    bit  accept;
    bit  pop;
    kind   = int'(d[7:6]);
    nib    = int'(d[3:0]);
    accept = e && v && (model_q.size() < DEPTH);
    pop    = e && r && (model_q.size() > 0);
    if (accept && kind == 3) begin
      modelReset();
      return;
    end
    if (pop) void'(model_q.pop_front());
    if (accept) begin
      case (kind)
        0: begin model_a = nib; have_a = 1; end
        1: begin model_b = nib; have_b = 1; end
        default: begin
          if (have_a && have_b) begin
            have_a = 0; have_b = 0;
            if (DIV_CHECK && d[1:0] == 2'b11 && model_b == 0) model_div = 1;
            else model_q.push_back('{op: int'(d[1:0]), a: model_a, b: model_b});
          end else begin
            model_seq = 1;
          end
        end
      endcase
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample 1ns after the edge
  task automatic applyStimulus(input bit e, input bit v, input logic [7:0] d, input bit r);
    ena = e; cmd_valid = v; cmd_data = d; issue_ready = r;
    modelStep(e, v, d, r);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(ena && model_q.size() < DEPTH));
    checkValue({tag, ".issue_valid"}, 32'(issue_valid), 32'(model_q.size() > 0));
    checkValue({tag, ".level"}, 32'(level), 32'(model_q.size()));
    checkValue({tag, ".seq_err"}, 32'(seq_err), 32'(model_seq));
    checkValue({tag, ".div_err"}, 32'(div_err), 32'(model_div));
    if (model_q.size() > 0) begin
      checkValue({tag, ".issue_a"}, 32'(issue_a), 32'(model_q[0].a));
      checkValue({tag, ".issue_b"}, 32'(issue_b), 32'(model_q[0].b));
      checkValue({tag, ".issue_op"}, 32'(issue_op), 32'(model_q[0].op));
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkValue({tag, ".level"}, 32'(level), 0);
    checkValue({tag, ".issue_valid"}, 32'(issue_valid), 0);
    checkValue({tag, ".issue_a"}, 32'(issue_a), 0);
    checkValue({tag, ".issue_b"}, 32'(issue_b), 0);
    checkValue({tag, ".issue_op"}, 32'(issue_op), 0);
    checkValue({tag, ".seq_err"}, 32'(seq_err), 0);
    checkValue({tag, ".div_err"}, 32'(div_err), 0);
    checkValue({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(ena));
  endtask

  task automatic resetDut();
    cmd_valid = 0; issue_ready = 0; ena = 1;
    rst_n = 0;
    #2;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1;
    modelReset();
    @(posedge clk);
    #1;
  endtask

  // Load A and B then issue GO with the given opcode
  task automatic queueOp(input int a, input int b, input int op);
    applyStimulus(1, 1, {2'b00, 2'b00, 4'(a)}, 0);
    applyStimulus(1, 1, {2'b01, 2'b00, 4'(b)}, 0);
    applyStimulus(1, 1, {2'b10, 4'b0000, 2'(op)}, 0);
  endtask

  initial begin
    ena = 1;
    #3;
    checkResetOutputs("power_on_reset");
    @(negedge clk);
    rst_n = 1;
    modelReset();
    @(posedge clk);
    #1;

    // Directed table: load/go basics, sequencing error, enable gating, clear
    vecs.push_back('{1,1,8'h03,0, 0,0,0,0,0, 0,1});
    vecs.push_back('{1,1,8'h45,0, 0,0,0,0,0, 0,1});
    vecs.push_back('{1,1,8'h80,0, 1,3,5,0,1, 0,1});
    vecs.push_back('{1,0,8'h00,1, 0,0,0,0,0, 0,1});
    vecs.push_back('{1,1,8'h09,0, 0,0,0,0,0, 0,1});
    vecs.push_back('{1,1,8'h81,0, 0,0,0,0,0, 1,1});
    vecs.push_back('{1,1,8'h42,0, 0,0,0,0,0, 1,1});
    vecs.push_back('{1,1,8'h82,0, 1,9,2,2,1, 1,1});
    vecs.push_back('{1,1,8'h41,0, 1,9,2,2,1, 1,1});
    vecs.push_back('{0,1,8'h80,1, 1,9,2,2,1, 1,0});
    vecs.push_back('{1,1,8'hC0,1, 0,0,0,0,0, 0,1});
    vecs.push_back('{1,1,8'h80,0, 0,0,0,0,0, 1,1});
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].e, vecs[i].v, vecs[i].d, vecs[i].r);
      checkValue($sformatf("vec%0d.issue_valid", i), 32'(issue_valid), 32'(vecs[i].x_valid));
      checkValue($sformatf("vec%0d.level", i), 32'(level), 32'(vecs[i].x_level));
      checkValue($sformatf("vec%0d.seq_err", i), 32'(seq_err), 32'(vecs[i].x_seq));
      checkValue($sformatf("vec%0d.cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].x_rdy));
      checkValue($sformatf("vec%0d.div_err", i), 32'(div_err), 0);
      if (vecs[i].x_valid) begin
        checkValue($sformatf("vec%0d.issue_a", i), 32'(issue_a), 32'(vecs[i].x_a));
        checkValue($sformatf("vec%0d.issue_b", i), 32'(issue_b), 32'(vecs[i].x_b));
        checkValue($sformatf("vec%0d.issue_op", i), 32'(issue_op), 32'(vecs[i].x_op));
      end
    end

    // Fill to DEPTH with the ALU stalled, then pop while a GO is pending
    resetDut();
    for (int i = 0; i < DEPTH; i++) queueOp(i + 1, i + 2, i % 4);
    checkValue("full.level", 32'(level), DEPTH);
    checkValue("full.cmd_ready", 32'(cmd_ready), 0);
    checkValue("full.issue_a", 32'(issue_a), 1);
    checkValue("full.issue_b", 32'(issue_b), 2);
    applyStimulus(1, 1, 8'h81, 1);
    checkValue("full_pop.level", 32'(level), DEPTH - 1);
    checkValue("full_pop.cmd_ready", 32'(cmd_ready), 1);
    checkValue("full_pop.issue_a", 32'(issue_a), 2);
    checkValue("full_pop.seq_err", 32'(seq_err), 0);
    applyStimulus(1, 1, 8'h81, 0);
    checkValue("pending_go.seq_err", 32'(seq_err), 1);
    checkValue("pending_go.level", 32'(level), DEPTH - 1);
    checkOutput("pending_go");

    // Divide by zero
    applyStimulus(1, 1, 8'hC0, 0);
    queueOp(7, 0, 3);
    if (DIV_CHECK) begin
      checkValue("div0.level", 32'(level), 0);
      checkValue("div0.div_err", 32'(div_err), 1);
      checkValue("div0.issue_valid", 32'(issue_valid), 0);
    end else begin
      checkValue("div0.level", 32'(level), 1);
      checkValue("div0.issue_a", 32'(issue_a), 7);
      checkValue("div0.issue_b", 32'(issue_b), 0);
      checkValue("div0.issue_op", 32'(issue_op), 3);
      checkValue("div0.div_err", 32'(div_err), 0);
    end
    applyStimulus(1, 1, 8'hC0, 0);
    checkValue("div0_clear.div_err", 32'(div_err), 0);
    checkValue("div0_clear.level", 32'(level), 0);

    // Queue of three, raise seq_err, then CLEAR together with a pop
    for (int i = 0; i < 3; i++) queueOp(i + 3, i, 1);
    applyStimulus(1, 1, 8'h80, 0);
    checkValue("q3.level", 32'(level), 3);
    checkValue("q3.seq_err", 32'(seq_err), 1);
    applyStimulus(1, 1, 8'hC0, 1);
    checkValue("q3_clear.level", 32'(level), 0);
    checkValue("q3_clear.issue_valid", 32'(issue_valid), 0);
    checkValue("q3_clear.seq_err", 32'(seq_err), 0);
    checkValue("q3_clear.div_err", 32'(div_err), 0);

    // Asynchronous reset in the middle of traffic
    queueOp(4, 6, 2);
    queueOp(5, 1, 0);
    applyStimulus(1, 1, 8'h80, 0);
    checkValue("mid.level", 32'(level), 2);
    checkValue("mid.seq_err", 32'(seq_err), 1);
    cmd_valid = 0;
    #2;
    rst_n = 0;
    #1;
    checkResetOutputs("async_reset");
    @(negedge clk);
    rst_n = 1;
    modelReset();
    @(posedge clk);
    #1;
    checkOutput("after_reset");

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int k;
      logic [1:0] kind;
      logic [7:0] d;
      k = int'($urandom_range(0, 15));
      kind = (k < 5) ? 2'b00 : (k < 10) ? 2'b01 : (k < 15) ? 2'b10 : 2'b11;
      d = {kind, 2'($urandom), 4'($urandom)};
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, d, $urandom_range(0, 2) == 0);
      checkOutput($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
